// File: rtl/asi_arb.sv
// Burst-granular read/write arbiter for the shared usr_clk memory port.
// Optional anti-starvation limit is enabled by defining ASI_ARB_STARVE_EN.
module asi_arb #(
   parameter int ASI_ARB  = 0,
   parameter int ARB_MAXB = 4,
   parameter int ARB_CW   = $clog2(ARB_MAXB + 1)
) (
   input  logic usr_clk,
   input  logic usr_reset_n,
   input  logic usr_rrequest,
   input  logic usr_re,
   input  logic usr_rlast,
   output logic usr_rgrant,
   input  logic usr_wrequest,
   input  logic usr_we,
   input  logic usr_wlast,
   output logic usr_wgrant,
   output logic usr_arb_busy,
   output logic usr_arb_err
);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD   = 2'd1,
      ARB_WR   = 2'd2
   } arb_st_t;

   localparam logic PRIO_RD = (ASI_ARB != 0);

   arb_st_t r_st;
   arb_st_t w_pick;
   logic    r_rgrant;
   logic    r_wgrant;
   logic    r_busy;
   logic    r_err;
   logic    w_rdone;
   logic    w_wdone;
   logic    w_rdone_own;
   logic    w_wdone_own;
   logic    w_decide;
   logic    w_starve;
   logic    w_err_evt;

   function automatic arb_st_t pick(input logic r, input logic w, input logic starve);
      arb_st_t res;
      if (r && w)
         res = (PRIO_RD ^ starve) ? ARB_RD : ARB_WR;
      else if (r)
         res = ARB_RD;
      else if (w)
         res = ARB_WR;
      else
         res = ARB_IDLE;
      return res;
   endfunction

   assign w_rdone     = usr_re & usr_rlast;
   assign w_wdone     = usr_we & usr_wlast;
   // Only a done strobe from the current owner ends a burst.
   assign w_rdone_own = (r_st == ARB_RD) & w_rdone;
   assign w_wdone_own = (r_st == ARB_WR) & w_wdone;
   assign w_decide    = ((r_st != ARB_RD) && (r_st != ARB_WR)) | w_rdone_own | w_wdone_own;

`ifdef ASI_ARB_STARVE_EN
   logic [ARB_CW-1:0] r_scnt;
   logic [ARB_CW-1:0] w_scnt_nxt;
   logic              w_low_req;
   logic              w_low_done;
   logic              w_prio_done;

   assign w_low_req   = PRIO_RD ? usr_wrequest : usr_rrequest;
   assign w_low_done  = PRIO_RD ? w_wdone_own  : w_rdone_own;
   assign w_prio_done = PRIO_RD ? w_rdone_own  : w_wdone_own;

   always_comb begin
      w_scnt_nxt = r_scnt;
      if (w_low_done)
         w_scnt_nxt = '0;
      else if (w_prio_done) begin
         if (!w_low_req)
            w_scnt_nxt = '0;
         else if (r_scnt < ARB_CW'(ARB_MAXB))
            w_scnt_nxt = r_scnt + 1'b1;
      end
   end

   // Decision uses the post-update count so the MAXB-th priority burst hands over.
   assign w_starve = (w_scnt_nxt >= ARB_CW'(ARB_MAXB));

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n)
         r_scnt <= '0;
      else
         r_scnt <= w_scnt_nxt;
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{32'(ARB_CW), 32'(ARB_MAXB)};
   assign w_starve     = 1'b0;
`endif

   assign w_pick = pick(usr_rrequest, usr_wrequest, w_starve);

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         r_st     <= ARB_IDLE;
         r_rgrant <= 1'b0;
         r_wgrant <= 1'b0;
         r_busy   <= 1'b0;
      end else if (w_decide) begin
         r_st     <= w_pick;
         r_rgrant <= (w_pick == ARB_RD);
         r_wgrant <= (w_pick == ARB_WR);
         r_busy   <= (w_pick != ARB_IDLE);
      end
   end

   assign w_err_evt = (usr_re & ~r_rgrant) | (usr_we & ~r_wgrant) | (usr_re & usr_we);

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n)
         r_err <= 1'b0;
      else if (w_err_evt)
         r_err <= 1'b1;
   end

   assign usr_rgrant   = r_rgrant;
   assign usr_wgrant   = r_wgrant;
   assign usr_arb_busy = r_busy;
   assign usr_arb_err  = r_err;

endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: vector table, directed corner sequences and a randomized
// run against a rule-level reference model (two instances: write / read priority).
module tb_asi_arb;

   localparam int IDLE = 0;
   localparam int RD   = 1;
   localparam int WR   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic a_rq = 0, a_re = 0, a_rl = 0, a_wq = 0, a_we = 0, a_wl = 0;
   logic b_rq = 0, b_re = 0, b_rl = 0, b_wq = 0, b_we = 0, b_wl = 0;
   logic a_rg, a_wg, a_busy, a_err;
   logic b_rg, b_wg, b_busy, b_err;

   asi_arb #(.ASI_ARB(0), .ARB_MAXB(2)) u_a (
      .usr_clk(clk), .usr_reset_n(rst_n),
      .usr_rrequest(a_rq), .usr_re(a_re), .usr_rlast(a_rl), .usr_rgrant(a_rg),
      .usr_wrequest(a_wq), .usr_we(a_we), .usr_wlast(a_wl), .usr_wgrant(a_wg),
      .usr_arb_busy(a_busy), .usr_arb_err(a_err)
   );

   asi_arb #(.ASI_ARB(1), .ARB_MAXB(4)) u_b (
      .usr_clk(clk), .usr_reset_n(rst_n),
      .usr_rrequest(b_rq), .usr_re(b_re), .usr_rlast(b_rl), .usr_rgrant(b_rg),
      .usr_wrequest(b_wq), .usr_we(b_we), .usr_wlast(b_wl), .usr_wgrant(b_wg),
      .usr_arb_busy(b_busy), .usr_arb_err(b_err)
   );

   int checks = 0;
   int errors = 0;

   int m_own [2] = '{IDLE, IDLE};
   int m_cnt [2] = '{0, 0};
   bit m_err [2] = '{0, 0};

   typedef struct packed {
      logic rq, re, rl, wq, we, wl, erg, ewg, eerr;
   } vec_t;
   vec_t tbl [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: owner as an int, starvation as "priority bursts won while low waited".
   task automatic model_step(input int k, input bit prio_rd, input int maxb,
                             input bit rq, input bit re, input bit rl,
                             input bit wq, input bit we, input bit wl);
      int  low_side, prio_side;
      bit  starve, owner_done;
      low_side  = prio_rd ? WR : RD;
      prio_side = prio_rd ? RD : WR;
      if ((re && m_own[k] != RD) || (we && m_own[k] != WR) || (re && we))
         m_err[k] = 1'b1;
      owner_done = (m_own[k] == RD && re && rl) || (m_own[k] == WR && we && wl);
`ifdef ASI_ARB_STARVE_EN
      if (owner_done && m_own[k] == low_side)
         m_cnt[k] = 0;
      else if (owner_done)
         m_cnt[k] = (prio_rd ? wq : rq) ? ((m_cnt[k] + 1 > maxb) ? maxb : m_cnt[k] + 1) : 0;
      starve = (m_cnt[k] >= maxb);
`else
      starve = (maxb < 0);
`endif
      if (m_own[k] == IDLE || owner_done) begin
         if (rq && wq)  m_own[k] = starve ? low_side : prio_side;
         else if (rq)   m_own[k] = RD;
         else if (wq)   m_own[k] = WR;
         else           m_own[k] = IDLE;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, 1'b0, 2, a_rq, a_re, a_rl, a_wq, a_we, a_wl);
      model_step(1, 1'b1, 4, b_rq, b_re, b_rl, b_wq, b_we, b_wl);
      #1;
   endtask

   task automatic set_a(input bit rq, input bit re, input bit rl, input bit wq, input bit we, input bit wl);
      a_rq = rq; a_re = re; a_rl = rl; a_wq = wq; a_we = we; a_wl = wl;
   endtask

   task automatic set_b(input bit rq, input bit re, input bit rl, input bit wq, input bit we, input bit wl);
      b_rq = rq; b_re = re; b_rl = rl; b_wq = wq; b_we = we; b_wl = wl;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk({tag, "_a_rg"},  a_rg, 0);
      chk({tag, "_a_wg"},  a_wg, 0);
      chk({tag, "_a_err"}, a_err, 0);
      chk({tag, "_b_busy"}, b_busy, 0);
      m_own = '{IDLE, IDLE};
      m_cnt = '{0, 0};
      m_err = '{0, 0};
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_a_rg"},   a_rg,   m_own[0] == RD);
      chk({tag, "_a_wg"},   a_wg,   m_own[0] == WR);
      chk({tag, "_a_busy"}, a_busy, m_own[0] != IDLE);
      chk({tag, "_a_err"},  a_err,  m_err[0]);
      chk({tag, "_b_rg"},   b_rg,   m_own[1] == RD);
      chk({tag, "_b_wg"},   b_wg,   m_own[1] == WR);
      chk({tag, "_b_busy"}, b_busy, m_own[1] != IDLE);
      chk({tag, "_b_err"},  b_err,  m_err[1]);
   endtask

   initial begin
      int exp_order [6];
      int own;
      bit rq, re, rl, wq, we, wl;

      //            rq re rl wq we wl  rg wg err
      tbl[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[2]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[3]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[4]  = '{1, 1, 1, 0, 0, 0,  1, 0, 0};
      tbl[5]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[6]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[7]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
      tbl[8]  = '{0, 1, 1, 0, 0, 0,  0, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0};
      tbl[10] = '{1, 1, 1, 0, 0, 0,  1, 0, 0};
      tbl[11] = '{1, 1, 1, 0, 0, 0,  1, 0, 0};
      tbl[12] = '{0, 1, 1, 0, 0, 0,  0, 0, 0};
      tbl[13] = '{0, 0, 0, 1, 0, 0,  0, 1, 0};
      tbl[14] = '{1, 0, 0, 1, 1, 0,  0, 1, 0};
      tbl[15] = '{1, 0, 0, 1, 1, 1,  0, 1, 0};
      tbl[16] = '{1, 0, 0, 0, 1, 1,  1, 0, 0};
      tbl[17] = '{0, 1, 1, 1, 0, 0,  0, 1, 0};
      tbl[18] = '{0, 0, 0, 1, 1, 0,  0, 1, 0};
      tbl[19] = '{0, 0, 0, 0, 1, 1,  0, 0, 0};
      tbl[20] = '{0, 1, 0, 0, 0, 0,  0, 0, 1};
      tbl[21] = '{0, 0, 0, 0, 0, 0,  0, 0, 1};

`ifdef ASI_ARB_STARVE_EN
      exp_order = '{WR, WR, RD, WR, WR, RD};
`else
      exp_order = '{WR, WR, WR, WR, WR, WR};
`endif

      // Reset with both requests pending: write priority wins on the first edge.
      set_a(1, 0, 0, 1, 0, 0);
      do_reset("rst0");
      chk("cyc0_rg", a_rg, 0);
      chk("cyc0_wg", a_wg, 0);
      tick();
      chk("cyc1_rg", a_rg, 0);
      chk("cyc1_wg", a_wg, 1);

      // Async reset mid-burst drops the grant without a clock edge.
      set_a(0, 0, 0, 1, 1, 0);
      do_reset("rst_mid");

      // Vector table on the write-priority instance.
      set_a(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++) begin
         set_a(tbl[i].rq, tbl[i].re, tbl[i].rl, tbl[i].wq, tbl[i].we, tbl[i].wl);
         tick();
         chk($sformatf("tbl%0d_rg", i),   a_rg,   tbl[i].erg);
         chk($sformatf("tbl%0d_wg", i),   a_wg,   tbl[i].ewg);
         chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].erg | tbl[i].ewg);
         chk($sformatf("tbl%0d_err", i),  a_err,  tbl[i].eerr);
      end
      set_a(0, 0, 0, 0, 0, 0);
      do_reset("rst_tbl");

      // Read priority: write request mid-burst is served exactly after rdone.
      set_b(1, 0, 0, 0, 0, 0);
      tick();
      chk("b_grant", b_rg, 1);
      set_b(1, 1, 0, 1, 0, 0);
      tick();
      chk("b_mid_rg", b_rg, 1);
      chk("b_mid_wg", b_wg, 0);
      set_b(0, 1, 1, 1, 0, 0);
      tick();
      chk("b_hand_rg", b_rg, 0);
      chk("b_hand_wg", b_wg, 1);
      set_b(1, 0, 0, 1, 1, 1);
      tick();
      chk("b_prio_rg", b_rg, 1);
      chk("b_prio_err", b_err, 0);
      set_b(0, 1, 1, 0, 0, 0);
      tick();
      chk("b_idle_busy", b_busy, 0);
      set_b(0, 0, 0, 0, 0, 0);

      // Write beat during a read grant: sticky error, grant unaffected.
      set_a(1, 0, 0, 0, 0, 0);
      tick();
      set_a(1, 0, 0, 0, 1, 0);
      tick();
      chk("err_set", a_err, 1);
      chk("err_rg", a_rg, 1);
      set_a(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("err_hold%0d", i), a_err, 1);
         chk($sformatf("err_rg%0d", i), a_rg, 1);
      end
      set_a(0, 0, 0, 0, 0, 0);
      do_reset("rst_err");

      // Both sides requesting continuously with 2-beat bursts.
      set_a(1, 0, 0, 1, 0, 0);
      tick();
      for (int b = 0; b < 6; b++) begin
         own = a_rg ? RD : (a_wg ? WR : IDLE);
         chk($sformatf("order%0d", b), own, exp_order[b]);
         if (a_rg) set_a(1, 1, 0, 1, 0, 0); else set_a(1, 0, 0, 1, 1, 0);
         tick();
         if (a_rg) set_a(1, 1, 1, 1, 0, 0); else set_a(1, 0, 0, 1, 1, 1);
         tick();
      end
      set_a(0, 0, 0, 0, 0, 0);
      do_reset("rst_order");

      // Randomized run against the model.
      for (int c = 0; c < 600; c++) begin
         if (c % 100 == 99) begin
            set_a(0, 0, 0, 0, 0, 0);
            set_b(0, 0, 0, 0, 0, 0);
            do_reset("rst_rnd");
         end
         rq = ($urandom_range(0, 3) != 0);
         wq = ($urandom_range(0, 3) != 0);
         re = (m_own[0] == RD) && ($urandom_range(0, 3) != 0);
         we = (m_own[0] == WR) && ($urandom_range(0, 3) != 0);
         rl = ($urandom_range(0, 2) == 0);
         wl = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) re = 1'b1;
         if ($urandom_range(0, 99) == 0) we = 1'b1;
         set_a(rq, re, rl, wq, we, wl);
         rq = ($urandom_range(0, 3) != 0);
         wq = ($urandom_range(0, 3) != 0);
         re = (m_own[1] == RD) && ($urandom_range(0, 3) != 0);
         we = (m_own[1] == WR) && ($urandom_range(0, 3) != 0);
         rl = ($urandom_range(0, 2) == 0);
         wl = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) re = 1'b1;
         if ($urandom_range(0, 99) == 0) we = 1'b1;
         set_b(rq, re, rl, wq, we, wl);
         tick();
         chk_model($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/asi_arb.md
# asi_arb

Burst-granular arbiter sharing the single user-side memory port between the AXI slave read interface (`asi_r`) and write interface (`asi_w`) in the `usr_clk` domain. It takes each side's request (`usr_rrequest` / `usr_wrequest`) and returns a registered grant (`usr_rgrant` / `usr_wgrant`). A grant is held from burst start through the last beat, so a burst is never split. Fixed priority is selected by `ASI_ARB`; an optional anti-starvation limit bounds how long the low-priority side can wait.

## Interface
Parameters:
- `ASI_ARB`, 0: 1 gives read priority; 0 gives write priority.
- `ARB_MAXB`, 4: maximum consecutive high-priority bursts while the low side waits (used only with `ASI_ARB_STARVE_EN`). Legal range is ≥1.
- `ARB_CW`, `$clog2(ARB_MAXB+1)`: derived; starvation counter width.

Ports:
- `usr_clk` in 1: the block's only clock.
- `usr_reset_n` in 1: asynchronous, active-low reset.
- `usr_rrequest` in 1: read side has at least one pending burst.
- `usr_re` in 1: read beat issued.
- `usr_rlast` in 1: qualifies `usr_re` as the last beat of a read burst.
- `usr_rgrant` out 1: read side owns the port.
- `usr_wrequest` in 1: write side has at least one pending burst.
- `usr_we` in 1: write beat issued.
- `usr_wlast` in 1: qualifies `usr_we` as the last beat of a write burst.
- `usr_wgrant` out 1: write side owns the port.
- `usr_arb_busy` out 1: a grant is active (`usr_rgrant|usr_wgrant`).
- `usr_arb_err` out 1: sticky protocol error flag.

## Operation
- FSM `{ARB_IDLE, ARB_RD, ARB_WR}`, registered.
  - `usr_rgrant = st==ARB_RD`.
  - `usr_wgrant = st==ARB_WR`.
  - The two grants are never asserted together.
- Read burst end: `rdone = usr_re & usr_rlast`. Write burst end: `wdone = usr_we & usr_wlast`.
- Decision function `pick(r,w)` returns RD, WR or IDLE:
  - If only one side requests, that side wins.
  - If both request, the priority side wins, unless `starve` is set; then the low side wins.
  - If neither requests, the result is IDLE.
- ARB_IDLE: next state is `pick(usr_rrequest, usr_wrequest)`.
- ARB_RD:
  - Stays in RD until `rdone`.
  - In the `rdone` cycle, next state is `pick(usr_rrequest, usr_wrequest)`. Back-to-back ownership by the same side is allowed.
- ARB_WR: symmetric to ARB_RD, using `wdone`.
- Requests are sampled only in ARB_IDLE and in done cycles; request changes mid-burst are ignored.
- A 1-beat burst (first beat also last) is a done cycle.
- Protocol error: `usr_arb_err` sets and stays set until reset on any of:
  - `usr_re` without `usr_rgrant`;
  - `usr_we` without `usr_wgrant`;
  - `usr_re & usr_we` in the same cycle.
- The FSM is not affected by these errors.

## Timing
- Reset: `st=ARB_IDLE`, all outputs 0, starvation counter 0.
- Grant latency from ARB_IDLE: request high at cycle T → grant high at T+1.
- Handover: done at T with the other side requesting → old grant low and new grant high at T+1. There are zero dead cycles and zero overlap.
- The requester may issue its first beat in the first cycle its grant is high.
- Reset asserted mid-burst: grants drop asynchronously. A burst in flight is abandoned; the requesters are reset in the same domain.
- A done strobe while in the opposite-owner state, or in ARB_IDLE, does not change state; it raises `usr_arb_err` through the beat-without-grant rule.

## Configuration
- Macro `ASI_ARB_STARVE_EN`.
- Defined:
  - Counter `scnt[ARB_CW-1:0]` increments on each done of the priority side, in cycles where the low side requests.
  - It clears to 0 on each done of the low side, or whenever the low side's request is low in the priority side's done cycle.
  - `starve = scnt>=ARB_MAXB`.
  - The counter saturates at `ARB_MAXB`.
- Undefined: `starve` is tied to 0; strict priority; no counter flops.

## Test plan
- Reset with both requests high, release reset → both grants 0 in cycle 0. With `ASI_ARB=0`, `usr_wgrant=1` at cycle 1 and `usr_rgrant=0`.
- Read only, two 4-beat bursts, `usr_rrequest` held high → `usr_rgrant` stays high across both bursts. It drops one cycle after the second `rdone` once `usr_rrequest=0`.
- `ASI_ARB=1`, write requests during a read burst → `usr_wgrant` rises exactly one cycle after `rdone`, with no overlap and no gap.
- With `ASI_ARB_STARVE_EN`, `ARB_MAXB=2`, `ASI_ARB=0`, both sides requesting continuously → grant order W,W,R,W,W,R. Without the macro → W only.
- 1-beat reads (`usr_re&usr_rlast` in the first granted cycle) back to back → `usr_rgrant` stays continuously high; one beat per burst.
- `usr_we` pulse while `usr_rgrant=1` → `usr_arb_err=1` the next cycle, stays 1 and clears only on `usr_reset_n`. Grants are unaffected.
